// File: rtl/sd_card_cmd_engine.sv
// Card-side SD CMD-line engine: receives 48-bit host commands, checks framing and CRC7,
// runs the identification state machine and returns R1/R2/R3/R6 responses.
module sd_card_cmd_engine #(
  parameter int           NCR       = 4,
  parameter int           TIME_BUSY = 64,
  parameter logic [15:0]  RCA_INIT  = 16'h0020,
  parameter logic [31:0]  OCR_INIT  = 32'h00FF8000,
  parameter logic [127:0] CID_INIT  = 128'h00ffffffddddddddaaaaaaaa99999999
) (
  input  logic        sdClk,
  input  logic        rst,
  input  logic        cmd_in,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        cmd_strobe,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic [3:0]  card_state,
  output logic        crc_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_SEND  = 3'd4;

  localparam logic [3:0] CS_IDLE  = 4'd0;
  localparam logic [3:0] CS_READY = 4'd1;
  localparam logic [3:0] CS_IDENT = 4'd2;
  localparam logic [3:0] CS_STBY  = 4'd3;
  localparam logic [3:0] CS_TRAN  = 4'd4;

  localparam int PW = $clog2(TIME_BUSY + 1);
  localparam logic [PW-1:0] PWR_MAX = PW'(TIME_BUSY);
  localparam logic [7:0] NCR_LAST = 8'(NCR - 1);

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [6:0] crc7_120(input logic [119:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // The CID body is fixed, so its CRC folds to a constant.
  localparam logic [119:0] CID_BODY = CID_INIT[127:8];
  localparam logic [6:0]   CID_CRC  = crc7_120(CID_BODY);

  logic [2:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [47:0]   shreg_q, shreg_d;
  logic [135:0]  resp_q, resp_d;
  logic          long_q, long_d;
  logic          cmd_oe_q, cmd_oe_d;
  logic          cmd_out_q, cmd_out_d;
  logic          strobe_q, strobe_d;
  logic          crc_err_q, crc_err_d;
  logic [5:0]    idx_q, idx_d;
  logic [31:0]   arg_q, arg_d;
  logic [3:0]    card_state_q, card_state_d;
  logic [15:0]   rca_q, rca_d;
  logic          app_q, app_d;
  logic          com_crc_q, com_crc_d;
  logic          illegal_q, illegal_d;
  logic [PW-1:0] pwr_cnt_q, pwr_cnt_d;

  logic        pwr_done;
  logic        frame_ok;
  logic        legal;
  logic        short_resp;
  logic [5:0]  rx_idx;
  logic [31:0] rx_arg;
  logic [31:0] status;
  logic [39:0] r1_body;
  logic [39:0] r6_body;

  always_comb begin
    status       = '0;
    status[23]   = com_crc_q;
    status[22]   = illegal_q;
    status[12:9] = card_state_q;
    status[5]    = app_q;
  end

  assign pwr_done = (pwr_cnt_q == PWR_MAX);
  assign rx_idx   = shreg_q[45:40];
  assign rx_arg   = shreg_q[39:8];
  assign frame_ok = shreg_q[46] && shreg_q[0] && (crc7_40(shreg_q[47:8]) == shreg_q[7:1]);
  assign r1_body  = {2'b00, rx_idx, status};
  assign r6_body  = {2'b00, rx_idx, RCA_INIT, status[23], status[22], status[19], status[12:0]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    resp_d       = resp_q;
    long_d       = long_q;
    cmd_oe_d     = cmd_oe_q;
    cmd_out_d    = cmd_out_q;
    strobe_d     = 1'b0;
    crc_err_d    = 1'b0;
    idx_d        = idx_q;
    arg_d        = arg_q;
    card_state_d = card_state_q;
    rca_d        = rca_q;
    app_d        = app_q;
    com_crc_d    = com_crc_q;
    illegal_d    = illegal_q;
    pwr_cnt_d    = pwr_done ? pwr_cnt_q : pwr_cnt_q + 1'b1;
    legal        = 1'b0;
    short_resp   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!cmd_in) begin
          shreg_d = {shreg_q[46:0], cmd_in};
          cnt_d   = 8'd1;
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        shreg_d = {shreg_q[46:0], cmd_in};
        cnt_d   = cnt_q + 8'd1;
        if (cnt_q == 8'd47) state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        if (!frame_ok) begin
          crc_err_d = 1'b1;
          com_crc_d = 1'b1;
        end else begin
          app_d = 1'b0;
          case (rx_idx)
            6'd0: begin
              legal        = 1'b1;
              card_state_d = CS_IDLE;
              rca_d        = '0;
              pwr_cnt_d    = '0;
            end
            6'd2: if (card_state_q == CS_READY) begin
              legal        = 1'b1;
              state_d      = S_WAIT;
              long_d       = 1'b1;
              resp_d       = {2'b00, 6'h3F, CID_BODY, CID_CRC, 1'b1};
              card_state_d = CS_IDENT;
            end
            6'd3: if (card_state_q == CS_IDENT) begin
              legal        = 1'b1;
              short_resp   = 1'b1;
              resp_d       = {r6_body, crc7_40(r6_body), 1'b1, 88'd0};
              rca_d        = RCA_INIT;
              card_state_d = CS_STBY;
            end
            6'd7: if (card_state_q == CS_STBY) begin
              legal      = 1'b1;
              short_resp = 1'b1;
              resp_d     = {r1_body, crc7_40(r1_body), 1'b1, 88'd0};
              if (rx_arg[31:16] == rca_q) card_state_d = CS_TRAN;
            end
            6'd55: begin
              legal      = 1'b1;
              short_resp = 1'b1;
              resp_d     = {r1_body, crc7_40(r1_body), 1'b1, 88'd0};
              app_d      = 1'b1;
            end
            6'd41: if (app_q && card_state_q == CS_IDLE) begin
              legal   = 1'b1;
              state_d = S_WAIT;
              long_d  = 1'b0;
              resp_d  = {2'b00, 6'h3F, pwr_done, OCR_INIT[30:0], 7'h7F, 1'b1, 88'd0};
              if (pwr_done) card_state_d = CS_READY;
            end
            6'd17, 6'd24, 6'd33: if (card_state_q == CS_TRAN) begin
              legal      = 1'b1;
              short_resp = 1'b1;
              resp_d     = {r1_body, crc7_40(r1_body), 1'b1, 88'd0};
            end
            default: ;
          endcase
          if (legal) begin
            strobe_d = 1'b1;
            idx_d    = rx_idx;
            arg_d    = rx_arg;
          end else begin
            illegal_d = 1'b1;
          end
          // R1/R6 carry the error flags out, which is what clears them.
          if (short_resp) begin
            state_d   = S_WAIT;
            long_d    = 1'b0;
            com_crc_d = 1'b0;
            illegal_d = 1'b0;
          end
        end
      end
      S_WAIT: begin
        cmd_oe_d  = 1'b1;
        cmd_out_d = 1'b1;
        cnt_d     = cnt_q + 8'd1;
        if (cnt_q == NCR_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (cnt_q == (long_q ? 8'd136 : 8'd48)) begin
          cmd_oe_d  = 1'b0;
          cmd_out_d = 1'b1;
          cnt_d     = 8'd0;
          state_d   = S_IDLE;
        end else begin
          cmd_out_d = resp_q[135];
          resp_d    = {resp_q[134:0], 1'b0};
          cnt_d     = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sdClk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      resp_q       <= '0;
      long_q       <= 1'b0;
      cmd_oe_q     <= 1'b0;
      cmd_out_q    <= 1'b1;
      strobe_q     <= 1'b0;
      crc_err_q    <= 1'b0;
      idx_q        <= '0;
      arg_q        <= '0;
      card_state_q <= CS_IDLE;
      rca_q        <= '0;
      app_q        <= 1'b0;
      com_crc_q    <= 1'b0;
      illegal_q    <= 1'b0;
      pwr_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      resp_q       <= resp_d;
      long_q       <= long_d;
      cmd_oe_q     <= cmd_oe_d;
      cmd_out_q    <= cmd_out_d;
      strobe_q     <= strobe_d;
      crc_err_q    <= crc_err_d;
      idx_q        <= idx_d;
      arg_q        <= arg_d;
      card_state_q <= card_state_d;
      rca_q        <= rca_d;
      app_q        <= app_d;
      com_crc_q    <= com_crc_d;
      illegal_q    <= illegal_d;
      pwr_cnt_q    <= pwr_cnt_d;
    end
  end

  assign cmd_out    = cmd_out_q;
  assign cmd_oe     = cmd_oe_q;
  assign cmd_strobe = strobe_q;
  assign crc_err    = crc_err_q;
  assign cmd_index  = idx_q;
  assign cmd_arg    = arg_q;
  assign card_state = card_state_q;

endmodule

// File: tb/tb_sd_card_cmd_engine.sv
// Bench for sd_card_cmd_engine: directed identification flow plus randomized commands,
// checked against a card model built from the command rules.
module tb_sd_card_cmd_engine;

  localparam int           NCR  = 4;
  localparam int           TB   = 400;
  localparam logic [15:0]  RCA  = 16'h0020;
  localparam logic [31:0]  OCR  = 32'h00FF8000;
  localparam logic [127:0] CID  = 128'h00ffffffddddddddaaaaaaaa99999999;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_in = 1'b1;
  logic        cmd_out, cmd_oe, cmd_strobe, crc_err;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [3:0]  card_state;

  sd_card_cmd_engine #(
    .NCR(NCR), .TIME_BUSY(TB), .RCA_INIT(RCA), .OCR_INIT(OCR), .CID_INIT(CID)
  ) dut (
    .sdClk(clk), .rst(rst), .cmd_in(cmd_in), .cmd_out(cmd_out), .cmd_oe(cmd_oe),
    .cmd_strobe(cmd_strobe), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .card_state(card_state), .crc_err(crc_err)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not reach its summary");
    $fatal(1, "timeout");
  end

  int checks = 0;
  int failures = 0;

  // card model
  logic [3:0]   m_state;
  bit           m_app, m_crc, m_ill;
  logic [15:0]  m_rca;
  int           m_restart;
  logic [5:0]   m_idx;
  logic [31:0]  m_arg;
  logic [135:0] last_cap;

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 4'd0; m_app = 0; m_crc = 0; m_ill = 0;
    m_rca = 16'h0; m_idx = 6'd0; m_arg = 32'd0; m_restart = cyc;
  endtask

  // CRC7 as polynomial long division by x^7+x^3+1 over the message times x^7.
  function automatic logic [6:0] crc7_ref(input logic [135:0] data, input int nbits);
    logic [7:0] rem;
    rem = 8'h00;
    for (int i = nbits - 1; i >= -7; i--) begin
      rem = {rem[6:0], (i >= 0) ? data[i] : 1'b0};
      if (rem[7]) rem = rem ^ 8'h89;
    end
    return rem[6:0];
  endfunction

  function automatic logic [31:0] status_now();
    logic [31:0] s;
    s = 32'd0;
    s[23] = m_crc; s[22] = m_ill; s[12:9] = m_state; s[5] = m_app;
    return s;
  endfunction

  // driver: frame bits go out on falling edges; returns on the falling edge after the end-bit edge
  task automatic send_bits(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge clk);
      cmd_in = f[i];
    end
    @(posedge clk);
    @(negedge clk);
    cmd_in = 1'b1;
  endtask

  task automatic run_frame(input logic [47:0] f, input bit good);
    logic [5:0]   idx;
    logic [31:0]  arg, st;
    logic [39:0]  body;
    logic [135:0] exp, cap, tmp;
    int           len, kind;
    bit           exp_strobe, exp_err, was_app, legal, pwr, pre_ok, oe_ok, quiet;
    idx = f[45:40]; arg = f[39:8];
    repeat ($urandom_range(0, 4)) @(negedge clk);
    send_bits(f);
    exp = '0; len = 0; kind = 0; exp_strobe = 0; exp_err = 0; legal = 0;
    pwr = (cyc - m_restart) > TB;
    st = status_now();
    if (!good) begin
      exp_err = 1; m_crc = 1;
    end else begin
      was_app = m_app; m_app = 0;
      case (idx)
        6'd0:  begin legal = 1; m_state = 0; m_rca = 0; m_restart = cyc; end
        6'd2:  if (m_state == 1) begin legal = 1; kind = 2; m_state = 2; end
        6'd3:  if (m_state == 2) begin legal = 1; kind = 6; m_rca = RCA; m_state = 3; end
        6'd7:  if (m_state == 3) begin legal = 1; kind = 1; if (arg[31:16] == m_rca) m_state = 4; end
        6'd55: begin legal = 1; kind = 1; m_app = 1; end
        6'd41: if (was_app && m_state == 0) begin legal = 1; kind = 3; if (pwr) m_state = 1; end
        6'd17, 6'd24, 6'd33: if (m_state == 4) begin legal = 1; kind = 1; end
        default: ;
      endcase
      if (legal) begin exp_strobe = 1; m_idx = idx; m_arg = arg; end
      else m_ill = 1;
      if (kind == 1 || kind == 6) begin m_crc = 0; m_ill = 0; end
    end
    case (kind)
      1: begin body = {2'b00, idx, st}; tmp = 136'(body);
               exp = 136'({body, crc7_ref(tmp, 40), 1'b1}); len = 48; end
      6: begin body = {2'b00, idx, m_rca, st[23], st[22], st[19], st[12:0]}; tmp = 136'(body);
               exp = 136'({body, crc7_ref(tmp, 40), 1'b1}); len = 48; end
      3: begin exp = 136'({2'b00, 6'h3F, pwr, OCR[30:0], 7'h7F, 1'b1}); len = 48; end
      2: begin tmp = 136'(CID[127:8]);
               exp = {2'b00, 6'h3F, CID[127:8], crc7_ref(tmp, 120), 1'b1}; len = 136; end
      default: ;
    endcase

    @(negedge clk);
    check("strobe", cmd_strobe, exp_strobe);
    check("crc_err", crc_err, exp_err);
    check("oe_before_ncr", cmd_oe, 1'b0);
    if (len > 0) begin
      pre_ok = 1;
      for (int k = 0; k < NCR; k++) begin
        @(negedge clk);
        if (!(cmd_oe === 1'b1 && cmd_out === 1'b1)) pre_ok = 0;
      end
      check("ncr_preamble", pre_ok, 1'b1);
      cap = '0; oe_ok = 1;
      for (int b = 0; b < len; b++) begin
        @(negedge clk);
        cap = {cap[134:0], cmd_out};
        if (cmd_oe !== 1'b1) oe_ok = 0;
      end
      last_cap = cap;
      check("response_bits", cap, exp);
      check("response_oe", oe_ok, 1'b1);
      @(negedge clk);
      check("oe_release", cmd_oe, 1'b0);
    end else begin
      quiet = 1;
      repeat (NCR + 3) begin
        @(negedge clk);
        if (cmd_oe !== 1'b0) quiet = 0;
      end
      check("no_response", quiet, 1'b1);
    end
    check("card_state", card_state, m_state);
    check("cmd_index", cmd_index, m_idx);
    check("cmd_arg", cmd_arg, m_arg);
  endtask

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input int flip);
    logic [39:0]  body;
    logic [135:0] tmp;
    logic [47:0]  f;
    body = {2'b01, idx, arg};
    tmp  = 136'(body);
    f    = {body, crc7_ref(tmp, 40), 1'b1};
    if (flip >= 0) f[flip] = ~f[flip];
    run_frame(f, flip < 0);
  endtask

  initial begin
    logic [5:0]  ridx;
    logic [31:0] rarg;
    int          r, flip;
    // reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_oe", cmd_oe, 1'b0);
    check("rst_cmd_out", cmd_out, 1'b1);
    check("rst_strobe", cmd_strobe, 1'b0);
    check("rst_crc_err", crc_err, 1'b0);
    check("rst_index", cmd_index, 6'd0);
    check("rst_arg", cmd_arg, 32'd0);
    check("rst_state", card_state, 4'd0);
    rst = 1'b0;
    model_reset();

    // CMD0 then ACMD41 before and after power-up
    run_frame(48'h400000000095, 1'b1);
    run_frame(48'h770000000065, 1'b1);
    run_cmd(6'd41, 32'h00FF8000, -1);
    check("ocr_busy", last_cap[39:8], 32'h00FF8000);
    repeat (TB + 60) @(negedge clk);
    run_cmd(6'd55, 32'h0, -1);
    run_cmd(6'd41, 32'h00FF8000, -1);
    check("ocr_ready", last_cap[39:8], 32'h80FF8000);

    // identification to transfer state
    run_cmd(6'd2, $urandom, -1);
    run_cmd(6'd3, $urandom, -1);
    check("r6_rca", last_cap[39:24], RCA);
    run_cmd(6'd7, {16'h1234 ^ 16'($urandom_range(0, 255)), 16'h0}, -1);
    run_cmd(6'd7, {RCA, 16'($urandom)}, -1);
    run_cmd(6'd17, $urandom, -1);

    // CRC error flag is reported once then cleared
    run_cmd(6'd55, 32'h0, $urandom_range(1, 7));
    run_cmd(6'd55, 32'h0, -1);
    check("com_crc_set", last_cap[31], 1'b1);
    run_cmd(6'd55, 32'h0, -1);
    check("com_crc_clear", last_cap[31], 1'b0);

    // illegal command in idle
    run_cmd(6'd0, 32'h0, -1);
    run_cmd(6'd17, $urandom, -1);
    run_cmd(6'd55, 32'h0, -1);
    check("illegal_set", last_cap[30], 1'b1);

    // reset in the middle of an R2
    repeat (TB + 60) @(negedge clk);
    run_cmd(6'd55, 32'h0, -1);
    run_cmd(6'd41, 32'h00FF8000, -1);
    send_bits({2'b01, 6'd2, 32'h0, crc7_ref(136'({2'b01, 6'd2, 32'h0}), 40), 1'b1});
    repeat (1 + NCR + 30) @(negedge clk);
    check("mid_send_oe", cmd_oe, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("reset_abort_oe", cmd_oe, 1'b0);
    check("reset_abort_state", card_state, 4'd0);
    rst = 1'b0;
    model_reset();
    run_cmd(6'd2, 32'h0, -1);

    // randomized command stream
    repeat (TB + 60) @(negedge clk);
    for (int n = 0; n < 28; n++) begin
      r = $urandom_range(0, 9);
      rarg = $urandom;
      case (r)
        0, 1: ridx = 6'd55;
        2: ridx = 6'd41;
        3: ridx = 6'd2;
        4: ridx = 6'd3;
        5: begin ridx = 6'd7; if ($urandom_range(0, 1) == 1) rarg[31:16] = m_rca; end
        6: ridx = 6'd17;
        7: ridx = ($urandom_range(0, 1) == 1) ? 6'd24 : 6'd33;
        default: begin ridx = 6'($urandom_range(1, 63)); end
      endcase
      flip = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 46) : -1;
      run_cmd(ridx, rarg, flip);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
